// File: rtl/alu_pipe_param.sv
// Elastic EX-stage ALU: forwards operands, computes result and branch condition,
// and carries them through STAGES valid/ready pipeline registers.
module alu_pipe_param #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ALUctl,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  input  logic [XLEN-1:0]  MEM_result,
  input  logic [XLEN-1:0]  WB_result,
  input  logic             MEM_fwd1,
  input  logic             MEM_fwd2,
  input  logic             WB_fwd1,
  input  logic             WB_fwd2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ALUOut,
  output logic             Branch_Enable,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SRL   = 4'b0011,
    ALU_SRA   = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SLT   = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_CSRRW = 4'b1001,
    ALU_CSRRS = 4'b1010,
    ALU_CSRRC = 4'b1011
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110
  } br_op_e;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] adv;

  logic [XLEN-1:0]  fwd_a, fwd_b;
  logic [XLEN-1:0]  a_q, b_q;
  logic [6:0]       ctl_q;
  logic [TAG_W-1:0] tag_q;
  logic [SHW-1:0]   shamt;
  logic [XLEN-1:0]  alu_res;
  logic             br_res;

  // Stage k may load when it, or any stage after it, is empty, or the consumer
  // takes the output; this lets bubbles collapse under a stalled tail.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & valid_q[k];
      adv[k]   = out_ready || !all_full;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];

  // MEM is the younger producer, so it wins over WB.
  assign fwd_a = MEM_fwd1 ? MEM_result : (WB_fwd1 ? WB_result : A);
  assign fwd_b = MEM_fwd2 ? MEM_result : (WB_fwd2 ? WB_result : B);

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: data registers are reset too, not just the valids, because the
      // outputs must read 0 while the block is in reset.
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      tag_q   <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else begin
        if (adv[0]) valid_q[0] <= in_valid;
        for (int k = 1; k < STAGES; k++) begin
          if (adv[k]) valid_q[k] <= valid_q[k-1];
        end
      end
      if (adv[0] && in_valid) begin
        a_q   <= fwd_a;
        b_q   <= fwd_b;
        ctl_q <= ALUctl;
        tag_q <= in_tag;
      end
    end
  end

  assign shamt = b_q[SHW-1:0];

  // NOTE: each output of a combinational block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    alu_res = '0;
    case (alu_op_e'(ctl_q[3:0]))
      ALU_AND:   alu_res = a_q & b_q;
      ALU_OR:    alu_res = a_q | b_q;
      ALU_XOR:   alu_res = a_q ^ b_q;
      ALU_ADD:   alu_res = a_q + b_q;
      ALU_SUB:   alu_res = a_q - b_q;
      ALU_SLT:   alu_res = XLEN'($signed(a_q) < $signed(b_q));
      ALU_SLL:   alu_res = a_q << shamt;
      ALU_SRL:   alu_res = a_q >> shamt;
      ALU_SRA:   alu_res = $signed(a_q) >>> shamt;
      ALU_CSRRW: alu_res = a_q;
      ALU_CSRRS: alu_res = a_q | b_q;
      ALU_CSRRC: alu_res = ~a_q & b_q;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    br_res = 1'b0;
    case (br_op_e'(ctl_q[6:4]))
      BR_BEQ:  br_res = (a_q == b_q);
      BR_BNE:  br_res = (a_q != b_q);
      BR_BLT:  br_res = ($signed(a_q) < $signed(b_q));
      BR_BGE:  br_res = ($signed(a_q) >= $signed(b_q));
      BR_BLTU: br_res = (a_q < b_q);
      BR_BGEU: br_res = (a_q >= b_q);
      default: br_res = 1'b0;
    endcase
  end

  if (STAGES > 1) begin : g_res
    logic [XLEN-1:0]  res_q  [STAGES-1:1];
    logic             br_q   [STAGES-1:1];
    logic [TAG_W-1:0] rtag_q [STAGES-1:1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 1; k < STAGES; k++) begin
          res_q[k]  <= '0;
          br_q[k]   <= 1'b0;
          rtag_q[k] <= '0;
        end
      end else begin
        if (adv[1] && valid_q[0]) begin
          res_q[1]  <= alu_res;
          br_q[1]   <= br_res;
          rtag_q[1] <= tag_q;
        end
        for (int k = 2; k < STAGES; k++) begin
          if (adv[k] && valid_q[k-1]) begin
            res_q[k]  <= res_q[k-1];
            br_q[k]   <= br_q[k-1];
            rtag_q[k] <= rtag_q[k-1];
          end
        end
      end
    end

    assign ALUOut        = res_q[STAGES-1];
    assign Branch_Enable = br_q[STAGES-1];
    assign out_tag       = rtag_q[STAGES-1];
  end else begin : g_single
    // With one stage the result is computed straight off the operand registers.
    assign ALUOut        = alu_res;
    assign Branch_Enable = br_res;
    assign out_tag       = tag_q;
  end

endmodule
